// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS-subset datapath: one memory port, one ALU, selects and write enables.
// Moore state outputs with Mealy mem_ready qualification in FETCH/MEMWR; waits on mem_ready with a timeout flag.
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OpCode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [8:0] LIMIT = 9'(WAIT_LIMIT);

    logic [3:0]       r_state;
    logic [3:0]       w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [8:0]       w_wait_inc;
    logic             w_waiting;
    logic             r_timeout;
    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = S_FETCH;
        case (r_state)
            S_FETCH:  w_state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OpCode)
                    OP_RTYPE:    w_state_nxt = S_EXEC;
                    OP_LW, OP_SW: w_state_nxt = S_MEMADR;
                    OP_BEQ:      w_state_nxt = S_BRANCH;
                    OP_J:        w_state_nxt = S_JUMP;
                    OP_ADDI:     w_state_nxt = S_ADDIEX;
                    default:     w_state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: w_state_nxt = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_state_nxt = S_RWB;
            S_ADDIEX: w_state_nxt = S_ADDIWB;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        // Reset masks everything so a concurrent mem_ready cannot load PC or IR.
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    illegal_op = !(OpCode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
                S_ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_waiting  = (r_state == S_FETCH || r_state == S_MEMRD || r_state == S_MEMWR) && !mem_ready;
    assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;

    // Counter saturates so a very long stall cannot wrap it back below the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else if (w_waiting) begin
            if (r_wait_cnt != 8'hFF) r_wait_cnt <= w_wait_inc[7:0];
            if (w_wait_inc >= LIMIT) r_timeout <= 1'b1;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)             r_retired <= '0;
        else if (instr_done) r_retired <= r_retired + CNT_W'(1);
    end

    assign state       = r_state;
    assign mem_timeout = r_timeout;
    assign retired     = r_retired;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences a multi-cycle version of the team's MIPS-subset datapath.
- Covers the same instruction set as the single-cycle CPU: R-type, lw, sw, beq, j, plus addi.
- Shares one memory port between instruction fetch and data access, and one ALU between PC increment, address generation and execution.
- Sits beside the datapath: takes the opcode from the instruction register and a memory ready strobe, and drives every mux select and write enable.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive cycles in a memory-wait state before mem_timeout is raised. Range 1..255.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- OpCode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register select: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- mem_timeout  out  1  sticky flag, cleared only by rst.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset: rst sampled at posedge. The next state is FETCH (0), retired = 0, the wait counter = 0, mem_timeout = 0.
- While rst is high, every control output is forced to 0, including PCWrite, IRWrite, MemRead and MemWrite.
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11
- Outputs not listed for a state are 0.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite = PCWrite = mem_ready (Mealy qualification).
  - Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next state by OpCode:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - any other opcode → FETCH, with illegal_op pulsed for this cycle and no retire.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead = 1, IorD = 1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0. Retires, then goes to FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Holds until mem_ready. Retires on the mem_ready cycle, then goes to FETCH.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Goes to RWB.
- RWB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Retires, then goes to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Retires, then goes to FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Retires, then goes to FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Retires, then goes to FETCH.
- Retire behaviour:
  - instr_done = 1 in the retiring cycle, which is the last cycle of the instruction.
  - retired increments at that clock edge and wraps modulo 2^CNT_W, with no saturation.
- Latency with mem_ready tied high:
  - R-type and addi: 4 cycles. lw: 5. sw: 4. beq: 3. j: 3.
  - Each wait cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Wait counter:
  - Counts consecutive cycles in FETCH, MEMRD or MEMWR with mem_ready = 0.
  - Clears on mem_ready = 1 or on leaving the state.
  - When it reaches WAIT_LIMIT, mem_timeout is set.
  - The FSM keeps waiting after mem_timeout is set; there is no abort.
- Memory-request hold: MemRead and MemWrite stay asserted and stable throughout a wait.
- Memory port exclusivity: MemRead and MemWrite are never both 1.
- Simultaneous rst and mem_ready: rst wins. No PC or IR write, state goes to FETCH.
- Reset mid-instruction: the instruction is abandoned with no retire, and the counter returns to 0.
- Undefined state encodings (12–15) are recovered to FETCH on the next edge, with all outputs 0 while in them.

Test Plan:
- rst = 1 for 2 cycles, then release with mem_ready = 1:
  - all outputs are 0 during reset;
  - the first cycle after release shows state = 0, MemRead = 1, IRWrite = 1, PCWrite = 1.
- mem_ready = 1, OpCode sequence 000000, 100011, 101011, 000100, 000010, 001000:
  - state traces are 0-1-6-7, 0-1-2-3-4, 0-1-2-5, 0-1-8, 0-1-9 and 0-1-10-11;
  - retired = 6 after 23 cycles.
- lw with mem_ready low for 3 cycles in MEMRD:
  - state stays 3 for 4 cycles, with MemRead = 1 and IorD = 1 held stable;
  - RegWrite = 1 occurs only in state 4.
- OpCode = 111111 in DECODE:
  - illegal_op pulses once, next state is 0, retired is unchanged.
- WAIT_LIMIT = 15, mem_ready = 0 for 20 cycles in FETCH:
  - mem_timeout rises after 15 wait cycles and stays 1;
  - the FSM advances when mem_ready goes to 1;
  - only rst clears mem_timeout.
- CNT_W = 4, retire 17 jumps:
  - retired = 1 (wrap);
  - rst asserted in MEMADR gives state = 0 and retired = 0 on the next edge.
